// File: rtl/axi_slave_mem_64b.sv
// AXI4 64-bit memory responder: independent write and read engines, one
// outstanding burst each, backed by a byte-writable word array.
module axi_slave_mem_64b #(
    parameter int                MEM_DEPTH = 1024,
    parameter int                ADDR_W    = 32,
    parameter int                ID_W      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              arst_n,
    // AW
    input  logic              aw_valid_i,
    input  logic [ID_W-1:0]   aw_id_i,
    input  logic [ADDR_W-1:0] aw_addr_i,
    input  logic [7:0]        aw_len_i,
    input  logic [2:0]        aw_size_i,
    input  logic [1:0]        aw_burst_i,
    input  logic [5:0]        aw_atop_i,
    output logic              aw_ready_o,
    // W
    input  logic              w_valid_i,
    input  logic [63:0]       w_data_i,
    input  logic [7:0]        w_strb_i,
    input  logic              w_last_i,
    output logic              w_ready_o,
    // B
    output logic              b_valid_o,
    output logic [ID_W-1:0]   b_id_o,
    output logic [1:0]        b_resp_o,
    output logic              b_user_o,
    input  logic              b_ready_i,
    // AR
    input  logic              ar_valid_i,
    input  logic [ID_W-1:0]   ar_id_i,
    input  logic [ADDR_W-1:0] ar_addr_i,
    input  logic [7:0]        ar_len_i,
    input  logic [2:0]        ar_size_i,
    input  logic [1:0]        ar_burst_i,
    output logic              ar_ready_o,
    // R
    output logic              r_valid_o,
    output logic [ID_W-1:0]   r_id_o,
    output logic [63:0]       r_data_o,
    output logic [1:0]        r_resp_o,
    output logic              r_last_o,
    output logic              r_user_o,
    input  logic              r_ready_i
);

    localparam int         IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] res;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_INCR: res = addr + step;
            BURST_WRAP: res = (addr & ~mask) | ((addr + step) & mask);
            default:    res = addr;
        endcase
        return res;
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return (addr < BASE_ADDR) ||
               (((addr - BASE_ADDR) >> 3) >= ADDR_W'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] mem_q [MEM_DEPTH];

    wstate_e           w_state_q, w_state_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic [5:0]        watop_q, watop_d;
    logic              werr_q, werr_d;
    logic              mem_we;
    logic              beat_bad;

    rstate_e           r_state_q, r_state_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_size;
    logic [1:0]        rd_burst;
    logic              rd_last;
    logic              rd_err;
    logic [63:0]       rd_data;
    logic [63:0]       r_data_q;
    logic [1:0]        r_resp_q;
    logic              r_last_q;

    // Write engine
    always_comb begin
        w_state_d  = w_state_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        watop_d    = watop_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        mem_we     = 1'b0;
        beat_bad   = 1'b0;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_o = arst_n;
                if (aw_valid_i) begin
                    wid_d     = aw_id_i;
                    waddr_d   = aw_addr_i;
                    wlen_d    = aw_len_i;
                    wsize_d   = aw_size_i;
                    wburst_d  = aw_burst_i;
                    watop_d   = aw_atop_i;
                    wcnt_d    = 8'd0;
                    werr_d    = (aw_burst_i == BURST_RSVD);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    beat_bad = out_of_range(waddr_q) || (watop_q != 6'd0) || (wsize_q > 3'd3);
                    mem_we   = !beat_bad;
                    // w_last only flags errors; the beat count alone ends the burst
                    if (beat_bad || (w_last_i != (wcnt_q == wlen_q)))
                        werr_d = 1'b1;
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (wcnt_q == wlen_q)
                        w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign b_id_o   = wid_q;
    assign b_resp_o = werr_q ? RESP_SLVERR : RESP_OKAY;
    assign b_user_o = 1'b0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (w_strb_i[b])
                    mem_q[word_idx(waddr_q)][8*b +: 8] <= w_data_i[8*b +: 8];
            end
        end
    end

    // Read engine: each beat is registered so R payload holds through stalls
    always_comb begin
        r_state_d  = r_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rcnt_d     = rcnt_q;
        rd_load    = 1'b0;
        rd_addr    = raddr_q;
        rd_size    = rsize_q;
        rd_burst   = rburst_q;
        rd_last    = 1'b0;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_o = arst_n;
                if (ar_valid_i) begin
                    rid_d     = ar_id_i;
                    raddr_d   = ar_addr_i;
                    rlen_d    = ar_len_i;
                    rsize_d   = ar_size_i;
                    rburst_d  = ar_burst_i;
                    rcnt_d    = 8'd0;
                    rd_load   = 1'b1;
                    rd_addr   = ar_addr_i;
                    rd_size   = ar_size_i;
                    rd_burst  = ar_burst_i;
                    rd_last   = (ar_len_i == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid_o = 1'b1;
                if (r_ready_i) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rd_addr = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        raddr_d = rd_addr;
                        rcnt_d  = rcnt_q + 8'd1;
                        rd_load = 1'b1;
                        rd_last = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        rd_err  = out_of_range(rd_addr) || (rd_size > 3'd3) || (rd_burst == BURST_RSVD);
        rd_data = rd_err ? 64'd0 : mem_q[word_idx(rd_addr)];
    end

    always_ff @(posedge clk) begin
        if (rd_load) begin
            r_data_q <= rd_data;
            r_resp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_last_q <= rd_last;
        end
    end

    assign r_id_o   = rid_q;
    assign r_data_o = r_data_q;
    assign r_resp_o = r_resp_q;
    assign r_last_o = r_last_q;
    assign r_user_o = 1'b0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_ff @(posedge clk) begin
        wid_q    <= wid_d;
        waddr_q  <= waddr_d;
        wlen_q   <= wlen_d;
        wsize_q  <= wsize_d;
        wburst_q <= wburst_d;
        watop_q  <= watop_d;
        wcnt_q   <= wcnt_d;
        werr_q   <= werr_d;
        rid_q    <= rid_d;
        raddr_q  <= raddr_d;
        rlen_q   <= rlen_d;
        rsize_q  <= rsize_d;
        rburst_q <= rburst_d;
        rcnt_q   <= rcnt_d;
    end

endmodule

// File: doc/axi_slave_mem_64b.md
Name: axi_slave_mem_64b

Overview:
- Synthesizable AXI4 memory responder on the 64-bit SNOC interface; the target end for the AXI master driver.
- Accepts snoc_req_s, returns snoc_resp_s, and backs transactions with an internal word array.
- Independent read and write engines, each with one outstanding burst.
- Serves as the DUT-side memory model in unit-level benches and as a scratch target in SoC sims.

Parameters:
- MEM_DEPTH, 1024, number of 64-bit words; power of two.
- BASE_ADDR, 0, byte address that maps to word 0; 8-byte aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- arst_n  input  1  reset; asynchronous, active-low.
- req  input  snoc_req_s  AW/W/AR channels plus b_ready and r_ready, from hydra_axi_pkg.
- resp  output  snoc_resp_s  aw_ready, w_ready, B, ar_ready and R channels.

Behaviour:
- Reset (arst_n low):
  - All resp valid and ready fields are 0; write and read FSMs go to IDLE.
  - Memory array is not reset.
  - First cycle after deassertion: aw_ready = 1 and ar_ready = 1.
- Address mapping:
  - widx = (addr - BASE_ADDR) >> 3.
  - A beat is out-of-range if addr < BASE_ADDR or widx >= MEM_DEPTH.
- Beat address update:
  - FIXED: address unchanged.
  - INCR: addr + (1 << size).
  - WRAP: increment, wrapping within an aligned block of (len+1) << size bytes.
  - Burst type 2'b11: treated as FIXED, burst response SLVERR.
- size > 3 forces SLVERR for the whole burst.
- User fields: b.user = 0, r.user = 0.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready = 1. On aw_valid, capture id, addr, len, size, burst and atop, clear the beat counter and go to W_DATA.
  - W_DATA: aw_ready = 0, w_ready = 1. On each w handshake:
    - Write byte lanes where strb = 1 into mem[widx]; other lanes are kept.
    - Skip the write if the beat is out-of-range, atop != 0, or size > 3, and set the error flag.
  - Leave W_DATA on the handshake where beat count == len.
  - If w_last disagrees with beat count == len on any beat, set the error flag. Transfer is still driven by the count.
  - W_RESP: b_valid = 1, b.id = captured id, b.resp = SLVERR (2'b10) if the error flag is set, else OKAY. Hold until b_ready, then W_IDLE.
  - Earliest aw acceptance after a B handshake: the next cycle.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ar_ready = 1. On ar_valid, capture the fields and go to R_DATA.
  - First r_valid appears the cycle after the AR handshake.
  - R_DATA:
    - r_valid = 1; r.id = captured id.
    - r.data = full 64-bit mem[widx]; the master selects lanes.
    - r.resp = OKAY, or SLVERR with data 0 if the beat is out-of-range or size > 3.
    - r.last = 1 on beat len.
  - r.data, r.resp and r.last are registered and stay stable while r_valid && !r_ready.
  - On r handshake: advance the address, register the next beat's data, and stay in R_DATA with r_valid = 1. After the last beat, return to R_IDLE.
  - Back-to-back beats are possible: 1 beat per cycle when r_ready is held high.
- Simultaneous events:
  - Read and write engines run concurrently.
  - A write committed on edge N is visible to any read beat registered on edge N+1 or later. A beat registered on edge N returns the old data.
  - AW and AR accepted in the same cycle is legal.
- Reset mid-burst:
  - The burst is abandoned; no B or R is issued for it.
  - Memory writes already committed remain.
- Width arithmetic:
  - Address arithmetic is SNOC_ADDRW wide and wraps modulo 2^SNOC_ADDRW.
  - Beat counter is 8 bits, matching len.

Test Plan:
1. Single write then read: AW addr 0x10, len 0, size 3, data 0xDEAD_BEEF_0123_4567, strb 0xFF. Then AR addr 0x10 -> B OKAY; R data 0xDEAD_BEEF_0123_4567, last = 1, resp OKAY, first r_valid 1 cycle after AR handshake.
2. INCR burst: write 4 beats at 0x100 with data 1..4, then read len 3 with r_ready toggling 1/0 -> R data 1, 2, 3, 4; r.last only on beat 4; data stable during stalls.
3. Partial strobe: fill word 0x20 with 0xFFFF_FFFF_FFFF_FFFF, then write 0 with strb 0x0F -> read returns 0xFFFF_FFFF_0000_0000.
4. WRAP burst: len 3, size 3, start 0x18 -> beats hit 0x18, 0x00, 0x08, 0x10. Read-back order matches.
5. Out-of-range / atop: write to BASE_ADDR + MEM_DEPTH*8 -> B SLVERR, memory unchanged. Read of the same address -> data 0, SLVERR. Write with atop != 0 -> SLVERR.
6. Reset mid-burst: assert arst_n low after beat 2 of a 4-beat write -> all valids 0 immediately. After release: no B issued, aw_ready = 1, beats 1–2 present in memory, beats 3–4 unchanged.
